scratchpad_loader: RTL and testbench
====================================

SCRATCHPAD_LOADER -- requirements
Module: scratchpad_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of scratchpad words addressed; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default TIA_WORD_WIDTH, meaning the data word width.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; asserted at 0.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a burst.
REQ-006 SHALL have port base_index  input  $clog2(DEPTH)  first scratchpad index of the burst, sampled on accepted start.
REQ-007 SHALL have port count  input  $clog2(DEPTH)+1  number of words in the burst, sampled on accepted start.
REQ-008 SHALL have port in_valid  input  1  source word available.
REQ-009 SHALL have port in_data  input  WIDTH  source word.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 SHALL have port write_req  output  1  host-side write request to the scratchpad.
REQ-012 SHALL have port write_index  output  $clog2(DEPTH)  scratchpad index for write_req.
REQ-013 SHALL have port write_data  output  WIDTH  scratchpad data for write_req.
REQ-014 SHALL have port write_ack  input  1  scratchpad accepted the write this cycle.
REQ-015 SHALL have port busy  output  1  burst in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-017 SHALL have port error  output  1  sticky flag: rejected burst (count > DEPTH); cleared by next accepted start or reset.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WRITE, FINISH.
REQ-019 SHALL accept start only in IDLE; start in any other state SHALL be ignored without side effects.
REQ-020 IDLE + start with count = 0 SHALL go to FINISH, issue no writes, clear error.
REQ-021 IDLE + start with count > DEPTH SHALL stay IDLE, set error, issue no writes, no done.
REQ-022 IDLE + start with 1 <= count <= DEPTH SHALL latch base_index into the index register and count into the remaining register, clear error, go to FETCH.
REQ-023 in_ready SHALL be 1 only in FETCH; in_valid && in_ready SHALL latch in_data into the data register and go to WRITE.
REQ-024 In WRITE, write_req SHALL be 1 with write_index and write_data held stable until the cycle in which write_ack = 1.
REQ-025 On WRITE with write_ack: the index register SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) and remaining SHALL decrement; next state SHALL be FINISH if remaining was 1, else FETCH.
REQ-026 write_ack outside WRITE SHALL be ignored.
REQ-027 Minimum throughput: one word per 2 cycles when in_valid and write_ack are held high; a word is written the cycle after it is accepted at the earliest.
REQ-028 FINISH SHALL assert done for exactly one cycle and return to IDLE the next cycle.
REQ-029 busy SHALL be 1 in FETCH, WRITE, FINISH; 0 in IDLE.
REQ-030 write_req, in_ready and done SHALL be registered state decodes with no combinational path from any input.
REQ-031 write_index and write_data SHALL come directly from registers.

Reset
REQ-032 Assertion of reset (0) SHALL immediately force IDLE and clear the index, remaining, data, error, done and busy state; write_req and in_ready SHALL be 0 asynchronously.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no further writes and no done pulse after release.
REQ-034 After reset is released, the first accepted start SHALL behave exactly as the first burst after power-up.

Verification
REQ-035 DEPTH=1024, start with base_index=4, count=3, words A,B,C with in_valid and write_ack always high -> writes (4,A),(5,B),(6,C); done on the cycle after the 3rd ack; no 4th write_req.
REQ-036 DEPTH=1024, base_index=1022, count=4 -> write indices 1022, 1023, 0, 1.
REQ-037 write_ack held low for 5 cycles in WRITE -> write_req, write_index and write_data stable for all 5 cycles; in_ready stays 0; exactly one write follows the ack.
REQ-038 count=0 -> done pulse 1 cycle after start; no write_req, no in_ready. count=1025 with DEPTH=1024 -> error=1, busy=0, no done; a following valid start clears error.
REQ-039 start pulsed while busy with a different base_index -> ignored; the original burst completes unchanged.
REQ-040 Reset pulsed after the 2nd of 4 writes -> write_req=0 and busy=0 immediately; no done; a new burst then completes normally.

Source files
------------

// File: rtl/scratchpad_loader.sv
// scratchpad_loader
//
// Copies a burst of words from a valid/ready source stream into a scratchpad
// through a request/acknowledge write port. A burst is requested with a
// single-cycle start carrying the first scratchpad index and the word count.
// Each word is fetched from the source into a data register, then held on
// the write port until the scratchpad acknowledges it. The index wraps modulo
// DEPTH.
//
// Parameters
//   DEPTH       number of scratchpad words (power of two, >= 2)
//   WIDTH       data word width
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous active-low reset
//   start       single-cycle burst request (honoured only when idle)
//   base_index  first scratchpad index, sampled on accepted start
//   count       number of words, sampled on accepted start (0..2*DEPTH-1)
//   in_valid    source word available
//   in_data     source word
//   in_ready    loader takes in_data this cycle
//   write_req   scratchpad write request
//   write_index scratchpad index for write_req
//   write_data  scratchpad data for write_req
//   write_ack   scratchpad accepted the write this cycle
//   busy        burst in progress
//   done        one-cycle pulse at burst completion
//   error       sticky: last start was rejected because count > DEPTH

`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

module scratchpad_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = `TIA_WORD_WIDTH,
    localparam int unsigned IW = $clog2(DEPTH),
    localparam int unsigned CW = IW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IW-1:0]    base_index,
    input  logic [CW-1:0]    count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             write_req,
    output logic [IW-1:0]    write_index,
    output logic [WIDTH-1:0] write_data,
    input  logic             write_ack,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StWrite  = 2'd2,
        StFinish = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    index_q, index_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             error_q, error_d;

    logic             count_too_big;
    logic             count_is_zero;
    logic             last_word;

    // count is one bit wider than the index so that a full-depth burst fits.
    assign count_too_big = (count > CW'(DEPTH));
    assign count_is_zero = (count == '0);
    assign last_word     = (remaining_q == CW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            index_q     <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        error_d     = error_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count_too_big) begin
                        // Rejected burst: flag it and stay idle, nothing else changes.
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        if (count_is_zero) begin
                            state_d = StFinish;
                        end else begin
                            index_d     = base_index;
                            remaining_d = count;
                            state_d     = StFetch;
                        end
                    end
                end
            end

            StFetch: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = StWrite;
                end
            end

            StWrite: begin
                if (write_ack) begin
                    // DEPTH is a power of two, so natural overflow wraps the index.
                    index_d     = index_q + IW'(1);
                    remaining_d = remaining_q - CW'(1);
                    state_d     = last_word ? StFinish : StFetch;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake outputs decode the state register only, so no input reaches
    // them combinationally and reset clears them asynchronously.
    assign in_ready    = (state_q == StFetch);
    assign write_req   = (state_q == StWrite);
    assign done        = (state_q == StFinish);
    assign busy        = (state_q != StIdle);
    assign write_index = index_q;
    assign write_data  = data_q;
    assign error       = error_q;

endmodule

// File: tb/tb_scratchpad_loader.sv
// Directed bench for scratchpad_loader (DEPTH=1024, WIDTH=32).

module tb_scratchpad_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  base_index;
    logic [10:0] count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        write_req;
    logic [9:0]  write_index;
    logic [31:0] write_data;
    logic        write_ack;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    // Write / done log, filled only by the monitor below.
    logic [9:0]  wr_idx [128];
    logic [31:0] wr_dat [128];
    int          wr_n   = 0;
    int          done_n = 0;

    scratchpad_loader #(
        .DEPTH(1024),
        .WIDTH(32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_index (base_index),
        .count      (count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .write_req  (write_req),
        .write_index(write_index),
        .write_data (write_data),
        .write_ack  (write_ack),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (write_req && write_ack) begin
            wr_idx[wr_n % 128] <= write_index;
            wr_dat[wr_n % 128] <= write_data;
            wr_n <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; base_index = '0; count = '0;
        in_valid = 1'b0; in_data = '0; write_ack = 1'b0;
        tick; tick;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (write_req !== 1'b0)  begin errors++; $display("FAIL reset_write_req: got %b expected 0", write_req); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (write_index !== 10'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", write_index); end
        checks++; if (write_data !== 32'd0)  begin errors++; $display("FAIL reset_data: got %0h expected 0", write_data); end
        reset = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    // Full burst with in_valid/write_ack high; optional stray start at cycle inject_at.
    task automatic run_burst(input string name, input logic [9:0] base, input logic [10:0] cnt,
                             input logic [31:0] seed, input int inject_at);
        int n0;
        int d0;
        int k;
        int cyc;
        bit seen_done;
        logic [9:0]  e_idx;
        logic [31:0] e_dat;
        n0 = wr_n; d0 = done_n; k = 0; cyc = 0; seen_done = 1'b0;
        start = 1'b1; base_index = base; count = cnt;
        in_valid = 1'b1; write_ack = 1'b1; in_data = seed;
        tick;
        start = 1'b0;
        while (cyc < 300) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (in_ready) begin
                in_data = seed + k;
                k++;
            end
            if (cyc == inject_at) begin
                start = 1'b1; base_index = base + 10'd100; count = 11'd1;
            end else begin
                start = 1'b0;
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        checks++; if (!seen_done) begin errors++; $display("FAIL %s_timeout: got no done expected done", name); end
        checks++;
        if (wr_n - n0 != int'(cnt)) begin
            errors++; $display("FAIL %s_write_count: got %0d expected %0d", name, wr_n - n0, cnt);
        end
        for (int j = 0; j < int'(cnt) && j < wr_n - n0; j++) begin
            e_idx = base + j[9:0];
            e_dat = seed + j;
            checks++;
            if (wr_idx[(n0 + j) % 128] !== e_idx) begin
                errors++; $display("FAIL %s_index%0d: got %0d expected %0d", name, j, wr_idx[(n0 + j) % 128], e_idx);
            end
            checks++;
            if (wr_dat[(n0 + j) % 128] !== e_dat) begin
                errors++; $display("FAIL %s_data%0d: got %0h expected %0h", name, j, wr_dat[(n0 + j) % 128], e_dat);
            end
        end
        tick;
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, done_n - d0); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL %s_idle_after: got %b expected 0", name, busy); end
        in_valid = 1'b0; write_ack = 1'b0;
    endtask

    // base 4, count 3: cycle-exact check of the write sequence and done timing.
    task automatic test_basic;
        int n0;
        int d0;
        n0 = wr_n; d0 = done_n;
        start = 1'b1; base_index = 10'd4; count = 11'd3;
        in_valid = 1'b1; write_ack = 1'b1; in_data = 32'hA1;
        tick;
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_fetch_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        tick;
        checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL basic_req_a: got %b expected 1", write_req); end
        checks++; if (write_index !== 10'd4 || write_data !== 32'hA1) begin
            errors++; $display("FAIL basic_write_a: got (%0d,%0h) expected (4,a1)", write_index, write_data);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_write: got %b expected 0", in_ready); end
        in_data = 32'hB2;
        tick;
        tick;
        checks++; if (write_index !== 10'd5 || write_data !== 32'hB2) begin
            errors++; $display("FAIL basic_write_b: got (%0d,%0h) expected (5,b2)", write_index, write_data);
        end
        in_data = 32'hC3;
        tick;
        tick;
        checks++; if (write_index !== 10'd6 || write_data !== 32'hC3 || write_req !== 1'b1) begin
            errors++; $display("FAIL basic_write_c: got (%0d,%0h,%b) expected (6,c3,1)", write_index, write_data, write_req);
        end
        tick;
        checks++; if (done !== 1'b1)      begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL basic_no_4th_req: got %b expected 0", write_req); end
        tick;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_back_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
        tick;
        checks++; if (wr_n - n0 != 3)   begin errors++; $display("FAIL basic_write_count: got %0d expected 3", wr_n - n0); end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_n - d0); end
        in_valid = 1'b0; write_ack = 1'b0;
    endtask

    task automatic test_stall;
        int n0;
        n0 = wr_n;
        start = 1'b1; base_index = 10'd10; count = 11'd2;
        in_valid = 1'b1; write_ack = 1'b0; in_data = 32'h5A5A0001;
        tick;
        start = 1'b0;
        tick;
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (write_req !== 1'b1 || write_index !== 10'd10 || write_data !== 32'h5A5A0001 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got req=%b idx=%0d data=%0h rdy=%b expected 1 10 5a5a0001 0",
                         i, write_req, write_index, write_data, in_ready);
            end
            tick;
        end
        checks++; if (wr_n - n0 != 0) begin errors++; $display("FAIL stall_no_write: got %0d expected 0", wr_n - n0); end
        write_ack = 1'b1;
        tick;
        checks++; if (wr_n - n0 != 1) begin errors++; $display("FAIL stall_one_write: got %0d expected 1", wr_n - n0); end
        checks++; if (write_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_refetch: got req=%b rdy=%b expected 0 1", write_req, in_ready);
        end
        in_data = 32'h5A5A0002;
        tick;
        tick;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
        checks++; if (wr_n - n0 != 2) begin errors++; $display("FAIL stall_total: got %0d expected 2", wr_n - n0); end
        checks++; if (wr_idx[(n0 + 1) % 128] !== 10'd11 || wr_dat[(n0 + 1) % 128] !== 32'h5A5A0002) begin
            errors++; $display("FAIL stall_second: got (%0d,%0h) expected (11,5a5a0002)",
                               wr_idx[(n0 + 1) % 128], wr_dat[(n0 + 1) % 128]);
        end
        tick;
        in_valid = 1'b0; write_ack = 1'b0;
    endtask

    task automatic test_overflow_and_zero;
        int n0;
        int d0;
        n0 = wr_n; d0 = done_n;
        start = 1'b1; base_index = 10'd0; count = 11'd1025;
        in_valid = 1'b1; write_ack = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b expected 1", error); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_idle: got busy=%b done=%b rdy=%b expected 0 0 0", busy, done, in_ready);
        end
        tick;
        checks++; if (error !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: got error=%b done=%b expected 1 0", error, done);
        end
        start = 1'b1; base_index = 10'd7; count = 11'd0;
        tick;
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1 1", done, busy);
        end
        checks++; if (write_req !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_no_xfer: got req=%b rdy=%b expected 0 0", write_req, in_ready);
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL zero_clears_error: got %b expected 0", error); end
        tick;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_back_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
        tick;
        checks++; if (wr_n - n0 != 0)   begin errors++; $display("FAIL ovfzero_writes: got %0d expected 0", wr_n - n0); end
        checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL ovfzero_dones: got %0d expected 1", done_n - d0); end
        // Set error again, then a normal burst must clear it.
        start = 1'b1; count = 11'd2000;
        tick;
        start = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf2_error: got %b expected 1", error); end
        in_valid = 1'b0; write_ack = 1'b0;
        run_burst("after_ovf", 10'd50, 11'd1, 32'h0000_7700, -1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf2_cleared: got %b expected 0", error); end
    endtask

    task automatic test_reset_mid;
        int n0;
        int d0;
        int cyc;
        n0 = wr_n; d0 = done_n; cyc = 0;
        start = 1'b1; base_index = 10'd20; count = 11'd4;
        in_valid = 1'b1; write_ack = 1'b1; in_data = 32'h0000_2000;
        tick;
        start = 1'b0;
        while (wr_n - n0 < 2 && cyc < 50) begin
            tick;
            cyc++;
        end
        checks++; if (wr_n - n0 != 2) begin errors++; $display("FAIL rst_mid_reach: got %0d expected 2", wr_n - n0); end
        tick;
        checks++; if (write_req !== 1'b1) begin errors++; $display("FAIL rst_mid_in_write: got %b expected 1", write_req); end
        reset = 1'b0;
        #1;
        checks++; if (write_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got req=%b busy=%b rdy=%b expected 0 0 0", write_req, busy, in_ready);
        end
        checks++; if (write_index !== 10'd0 || write_data !== 32'd0) begin
            errors++; $display("FAIL rst_mid_clear: got (%0d,%0h) expected (0,0)", write_index, write_data);
        end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick;
        checks++; if (wr_n - n0 != 2)   begin errors++; $display("FAIL rst_mid_no_more_writes: got %0d expected 2", wr_n - n0); end
        checks++; if (done_n - d0 != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_n - d0); end
        in_valid = 1'b0; write_ack = 1'b0;
        run_burst("after_rst", 10'd30, 11'd2, 32'h0000_3000, -1);
    endtask

    initial begin
        test_reset;
        test_basic;
        run_burst("wrap", 10'd1022, 11'd4, 32'h1111_0000, -1);
        test_stall;
        test_overflow_and_zero;
        run_burst("ignore_start", 10'd100, 11'd3, 32'h2222_0000, 2);
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
